fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: halfword address holding the 32-bit start PC.
REQ-002 SHALL have parameter HLT_OPCODE, default 5'b00001: opcode in inst_data[31:27] that marks a halt.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 inst_addr  out  32  halfword address to instruction memory; combinational from the PC register.
REQ-006 inst_data  in  32  {mem[inst_addr], mem[inst_addr+1]}; combinational, valid in the same cycle.
REQ-007 stall  in  1  hold the PC and the IF/ID register.
REQ-008 flush  in  1  replace the next IF/ID contents with a bubble.
REQ-009 redirect  in  1  load redirect_pc as the next PC (branch, jump or return).
REQ-010 redirect_pc  in  32  target halfword address.
REQ-011 ifid_inst  out  32  registered instruction; 16-bit instructions sit in [31:16], with [15:0] zero.
REQ-012 ifid_pc  out  32  registered address of ifid_inst.
REQ-013 ifid_next_pc  out  32  registered PC plus instruction length, used as the link value.
REQ-014 ifid_valid  out  1  ifid_* hold a real instruction.
REQ-015 halted  out  1  fetch is frozen by a halt.

Function
REQ-016 SHALL implement the states VEC, RUN and HALT.
REQ-017 In VEC: inst_addr = RESET_VECTOR; on the next edge PC <= inst_data, ifid_valid stays 0, and the state goes to RUN; stall, flush and redirect are ignored.
REQ-018 Length rule: inst_data[26]=1 means a 32-bit instruction (PC += 2); otherwise a 16-bit instruction (PC += 1), with ifid_inst = {inst_data[31:16],16'h0}.
REQ-019 Wrap-around: PC arithmetic is modulo 2^32; 32'hFFFF_FFFF + 1 = 0, and + 2 = 1.
REQ-020 Priority in RUN: redirect > stall > normal advance.
REQ-021 Redirect: PC <= redirect_pc; ifid_valid <= 0 for that edge; the target appears in IF/ID one cycle later (one-bubble penalty).
REQ-022 Stall without redirect: PC and all ifid_* hold unchanged.
REQ-023 Flush without stall: ifid_valid <= 0 and ifid_inst <= 0; the PC still advances unless redirect is also high.
REQ-024 Flush and stall together: flush wins for IF/ID (bubble inserted); the PC holds.
REQ-025 Normal advance: ifid_inst, ifid_pc <= PC, ifid_next_pc <= next PC, ifid_valid <= 1, PC <= next PC.
REQ-026 Fetch latency SHALL be 1 cycle from PC to IF/ID.
REQ-027 halted SHALL be 1 exactly in HALT.

Reset
REQ-028 rst high SHALL immediately force state=VEC, PC=RESET_VECTOR, ifid_inst=0, ifid_pc=0, ifid_next_pc=0, ifid_valid=0, halted=0.
REQ-029 Reset asserted mid-operation, including in HALT or during a stall, SHALL discard all state; fetch restarts from VEC after rst deasserts.
REQ-030 The first clock edge after deassertion SHALL perform the VEC load.

Configuration
REQ-031 Macro FETCH_HALT_EN.
REQ-032 Defined: in RUN, when a fetched instruction has opcode == HLT_OPCODE and is not stalled or redirected, it enters IF/ID normally, the PC freezes at its address, and the state goes to HALT.
REQ-033 Defined: in HALT, IF/ID is held as bubbles (ifid_valid=0), and only redirect (PC <= redirect_pc, state -> RUN) or rst leaves the state.
REQ-034 Not defined: the HALT state is absent, halted is tied to 0, and the HLT opcode is fetched like any other instruction.

Structure
REQ-035 A shared package SHALL hold the state encoding (VEC=2'd0, RUN=2'd1, HALT=2'd2), the length-bit index (26), the opcode field range [31:27] and the HLT_OPCODE default.
REQ-036 A single sub-module, pc_incr, SHALL compute the next PC from the PC and the length bit; everything else stays in fetch_unit.
REQ-037 fetch_unit SHALL connect to INST_MEM without glue: inst_addr to address, inst_data from data_out.

Verification
REQ-038 Reset vector: mem[0]=16'h0000, mem[1]=16'h0040, release rst -> first valid ifid_pc=32'h40 after 2 edges.
REQ-039 Length mix: 16-bit at 0x40, 32-bit at 0x41, 16-bit at 0x43 -> ifid_pc sequence 0x40, 0x41, 0x43 with ifid_next_pc 0x41, 0x43, 0x44.
REQ-040 Redirect with stall: redirect=1, stall=1, redirect_pc=0x100 -> one bubble (ifid_valid=0), next valid ifid_pc=0x100.
REQ-041 Flush with stall: flush=1, stall=1 at PC 0x50 -> ifid_valid=0, PC holds at 0x50; after release the next ifid_pc=0x50.
REQ-042 Wrap: PC=32'hFFFF_FFFF holding a 32-bit instruction -> ifid_next_pc=32'h1, next PC=1.
REQ-043 Halt (FETCH_HALT_EN defined): HLT at 0x60 -> HLT valid in IF/ID, halted=1, PC stays 0x60; redirect to 0x80 -> halted=0, fetch resumes; rst asserted in HALT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: state encoding, instruction field
// positions and the default halt opcode.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        VEC  = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int          LEN_BIT        = 26;
    localparam int          OPC_MSB        = 31;
    localparam int          OPC_LSB        = 27;
    localparam logic [4:0]  HLT_OPCODE_DEF = 5'b00001;

endpackage

// File: rtl/fetch_unit_pc_incr.sv
// Next-PC adder: advances a halfword PC by one (16-bit instruction) or two
// (32-bit instruction), wrapping modulo 2^32.
module pc_incr (
    input  logic [31:0] pc,
    input  logic        is_long,
    output logic [31:0] next_pc
);

    assign next_pc = pc + (is_long ? 32'd2 : 32'd1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with reset-vector load and IF/ID pipeline register.
// Optional halt-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [4:0]  HLT_OPCODE   = HLT_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_next_pc,
    output logic        ifid_valid,
    output logic        halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         is_long;
    logic         is_hlt;

    assign is_long   = inst_data[LEN_BIT];
    assign is_hlt    = HALT_EN && (inst_data[OPC_MSB:OPC_LSB] == HLT_OPCODE);
    assign inst_addr = (state == VEC) ? RESET_VECTOR : pc;

    pc_incr u_pc_incr (
        .pc      (pc),
        .is_long (is_long),
        .next_pc (next_pc)
    );

    // PC, state and IF/ID register; redirect beats stall beats normal advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= VEC;
            pc           <= RESET_VECTOR;
            ifid_inst    <= 32'h0;
            ifid_pc      <= 32'h0;
            ifid_next_pc <= 32'h0;
            ifid_valid   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            case (state)
                VEC: begin
                    pc    <= inst_data;
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                        ifid_inst  <= 32'h0;
                    end else if (stall) begin
                        if (flush) begin
                            ifid_valid <= 1'b0;
                            ifid_inst  <= 32'h0;
                        end
                    end else begin
                        if (flush) begin
                            ifid_valid <= 1'b0;
                            ifid_inst  <= 32'h0;
                        end else begin
                            ifid_inst    <= is_long ? inst_data : {inst_data[31:16], 16'h0};
                            ifid_pc      <= pc;
                            ifid_next_pc <= next_pc;
                            ifid_valid   <= 1'b1;
                        end
                        // A halt freezes the PC on the halt instruction itself
                        if (is_hlt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    ifid_valid <= 1'b0;
                    ifid_inst  <= 32'h0;
                    if (redirect) begin
                        pc     <= redirect_pc;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
`endif
                default: begin
                    state      <= VEC;
                    pc         <= RESET_VECTOR;
                    ifid_valid <= 1'b0;
                    ifid_inst  <= 32'h0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a halfword memory model feeds inst_data, a
// behavioural model predicts IF/ID each cycle, and a monitor compares.
module tb_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [4:0]  HLT = 5'b00001;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_inst, ifid_pc, ifid_next_pc;
    logic        ifid_valid, halted;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr    (inst_addr),
        .inst_data    (inst_data),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ifid_inst    (ifid_inst),
        .ifid_pc      (ifid_pc),
        .ifid_next_pc (ifid_next_pc),
        .ifid_valid   (ifid_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Sparse memory: written halfwords, otherwise a seeded hash that never yields HLT
    logic [15:0] mem [logic [31:0]];
    logic [15:0] seed;
    int          mem_gen = 0;

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [15:0] h;
        if (mem.exists(a)) return mem[a];
        h = (a[15:0] * 16'h9E37) ^ a[31:16] ^ seed;
        if (h[15:11] == HLT) h[15] = ~h[15];
        return h;
    endfunction

    function automatic logic [31:0] fetch32(input logic [31:0] a);
        return {hw(a), hw(a + 32'd1)};
    endfunction

    always @(inst_addr, mem_gen) inst_data = fetch32(inst_addr);

    typedef struct {
        bit          v;
        bit          h;
        bit          z;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: 0 = loading vector, 1 = running, 2 = halted
    int          m_state;
    logic [31:0] m_pc;
    bit          m_v;
    logic [31:0] m_inst, m_ipc, m_npc;

    task automatic model_reset();
        m_state = 0; m_pc = RV; m_v = 1'b0;
        m_inst = 32'h0; m_ipc = 32'h0; m_npc = 32'h0;
    endtask

    task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
        logic [31:0] ins, np;
        bit          zero;
        @(negedge clk);
        #1;
        rst = 1'b0; stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        chk("inst_addr", inst_addr, m_pc);
        zero = 1'b0;
        if (m_state == 0) begin
            m_pc    = fetch32(RV);
            m_state = 1;
        end else if (m_state == 1) begin
            ins = fetch32(m_pc);
            np  = m_pc + (ins[26] ? 32'd2 : 32'd1);
            if (rd) begin
                m_pc = rpc; m_v = 1'b0;
            end else if (st) begin
                if (fl) begin m_v = 1'b0; zero = 1'b1; end
            end else begin
                if (fl) begin
                    m_v = 1'b0; zero = 1'b1;
                end else begin
                    m_v = 1'b1; m_ipc = m_pc; m_npc = np;
                    m_inst = ins[26] ? ins : {ins[31:16], 16'h0};
                end
                if (HALT_EN && ins[31:27] == HLT) m_state = 2;
                else m_pc = np;
            end
        end else begin
            m_v = 1'b0;
            if (rd) begin m_pc = rpc; m_state = 1; end
        end
        q.push_back('{v: m_v, h: (m_state == 2), z: zero, inst: m_inst, pc: m_ipc, npc: m_npc});
    endtask

    task automatic check_reset_outputs();
        chk("rst_ifid_inst", ifid_inst, 32'h0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_next_pc", ifid_next_pc, 32'h0);
        chk("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_inst_addr", inst_addr, RV);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [15:0] d);
        mem[a] = d;
        mem_gen++;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, mon_e.v});
            chk("halted", {31'h0, halted}, {31'h0, mon_e.h});
            if (mon_e.v) begin
                chk("ifid_inst", ifid_inst, mon_e.inst);
                chk("ifid_pc", ifid_pc, mon_e.pc);
                chk("ifid_next_pc", ifid_next_pc, mon_e.npc);
            end
            if (mon_e.z) chk("flush_inst_zero", ifid_inst, 32'h0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        seed = 16'($urandom);
        wr(32'h0, 16'h0000);  wr(32'h1, 16'h0040);
        wr(32'h40, 16'h1000);
        wr(32'h41, 16'h2400); wr(32'h42, 16'hBEEF);
        wr(32'h43, 16'h3000);
        wr(32'hFFFF_FFFF, 16'h0400);
        wr(32'h60, 16'h0800);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();

        // Vector load then a 16/32/16-bit mix
        step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect together with stall
        step(1'b1, 1'b0, 1'b1, 32'h100);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Flush together with stall at 0x50
        step(1'b0, 1'b0, 1'b1, 32'h50);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Flush alone still advances the PC
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Wrap-around on a 32-bit instruction at the top of memory
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Halt at 0x60, linger, then redirect out
        step(1'b0, 1'b0, 1'b1, 32'h60);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h80);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Halt again, then reset while halted and stalled
        step(1'b0, 1'b0, 1'b1, 32'h60);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic with occasional halts and resets
        for (int i = 0; i < 500; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) wr(tgt, {HLT, 11'($urandom)});
            if ($urandom_range(0, 149) == 0) do_reset();
            else step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 9) == 0, tgt);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
